// File: rtl/param_counter.sv
// Parametrised up/down counter with a programmable terminal value, prescaled tick,
// wrap / saturate / one-shot end-of-count modes, synchronous clear and parallel load.
module param_counter #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  dir,
  input  logic [1:0]            mode,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  done
);

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'b00,
    MODE_SAT      = 2'b01,
    MODE_ONESHOT  = 2'b10,
    MODE_WRAP_RSV = 2'b11
  } mode_e;

  logic [WIDTH-1:0]      count_q, count_d;
  logic [PRESCALE_W-1:0] psc_q, psc_d;
  logic                  tc_q, tc_d;
  logic                  done_q, done_d;

  logic                  tick;
  logic                  at_bnd;
  logic [WIDTH-1:0]      bound;
  logic [WIDTH-1:0]      step;
  mode_e                 mode_sel;

  assign mode_sel = mode_e'(mode);
  assign tick     = en && (psc_q == prescale);
  assign bound    = dir ? '0 : limit;
  // Up-count boundary uses >= so loaded or limit-lowered out-of-range values still terminate.
  assign at_bnd   = dir ? (count_q == '0) : (count_q >= limit);
  assign step     = dir ? (count_q - 1'b1) : (count_q + 1'b1);

  // NOTE: every combinational output gets a default first, so no path leaves a latch.
  always_comb begin
    count_d = count_q;
    psc_d   = psc_q;
    tc_d    = 1'b0;
    done_d  = done_q;

    if (clr) begin
      count_d = '0;
      psc_d   = '0;
      done_d  = 1'b0;
    end else if (load) begin
      count_d = load_val;
      psc_d   = '0;
      done_d  = 1'b0;
    end else if (en) begin
      // A prescale lowered below psc lets psc run on and wrap before matching again.
      psc_d = tick ? '0 : psc_q + 1'b1;

      if (tick) begin
        case (mode_sel)
          MODE_SAT: begin
            if (!at_bnd) begin
              count_d = step;
              tc_d    = (step == bound);
            end
          end
          MODE_ONESHOT: begin
            if (!done_q) begin
              if (at_bnd) begin
                done_d = 1'b1;
              end else begin
                count_d = step;
                tc_d    = (step == bound);
                done_d  = (step == bound);
              end
            end
          end
          default: begin
            if (at_bnd) begin
              count_d = dir ? limit : '0;
              tc_d    = 1'b1;
            end else begin
              count_d = step;
            end
          end
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      psc_q   <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      psc_q   <= psc_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign done  = done_q;

endmodule

// File: tb/tb_param_counter.sv
// Directed bench for param_counter: a behavioural model pushes expected {count,tc,done}
// into a scoreboard queue as each cycle is driven; the entry is popped after the edge.
module tb_param_counter;

  localparam int W  = 8;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en, clr, load, dir;
  logic [W-1:0]  load_val, limit;
  logic [1:0]    mode;
  logic [PW-1:0] prescale;
  logic [W-1:0]  count;
  logic          tc, done;

  param_counter #(.WIDTH(W), .PRESCALE_W(PW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .dir      (dir),
    .mode     (mode),
    .limit    (limit),
    .prescale (prescale),
    .count    (count),
    .tc       (tc),
    .done     (done)
  );

  always #5 clk = ~clk;

  int unsigned   n_tests = 0;
  int unsigned   n_fail  = 0;
  logic [W+1:0]  sb_q[$];

  // Model state
  int            m_cnt, m_psc;
  logic          m_tc, m_done;

  task automatic model_reset();
    m_cnt = 0; m_psc = 0; m_tc = 1'b0; m_done = 1'b0;
  endtask

  // Expected state after the coming edge, from the current inputs and model state.
  task automatic model_next();
    int  nc, lim;
    logic tk;
    nc  = m_cnt;
    lim = int'(limit);
    tk  = 1'b0;
    m_tc = 1'b0;
    if (clr) begin
      m_cnt = 0; m_psc = 0; m_done = 1'b0;
    end else if (load) begin
      m_cnt = int'(load_val); m_psc = 0; m_done = 1'b0;
    end else if (en) begin
      if (m_psc == int'(prescale)) begin tk = 1'b1; m_psc = 0; end
      else m_psc = (m_psc + 1) % (1 << PW);
      if (tk) begin
        if (mode == 2'b00 || mode == 2'b11) begin
          if (!dir) begin
            if (m_cnt >= lim) begin nc = 0; m_tc = 1'b1; end else nc = m_cnt + 1;
          end else begin
            if (m_cnt == 0) begin nc = lim; m_tc = 1'b1; end else nc = m_cnt - 1;
          end
        end else if (!(mode == 2'b10 && m_done)) begin
          if (!dir) begin
            if (m_cnt < lim) begin nc = m_cnt + 1; m_tc = (nc == lim); end
            else if (mode == 2'b10) m_done = 1'b1;
          end else begin
            if (m_cnt > 0) begin nc = m_cnt - 1; m_tc = (nc == 0); end
            else if (mode == 2'b10) m_done = 1'b1;
          end
          if (mode == 2'b10 && m_tc) m_done = 1'b1;
        end
        m_cnt = nc;
      end
    end
  endtask

  // Drive one clock: push expectation, take the edge, pop and compare 1 time unit later.
  task automatic cycle(input string tag);
    logic [W+1:0] exp_v, act_v;
    model_next();
    sb_q.push_back({m_cnt[W-1:0], m_tc, m_done});
    @(posedge clk);
    #1;
    act_v = {count, tc, done};
    n_tests++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s scoreboard empty, observed %h", tag, act_v);
    end else begin
      exp_v = sb_q.pop_front();
      assert (act_v === exp_v) else begin
        n_fail++;
        $error("FAIL %s observed count=%0d tc=%0b done=%0b expected count=%0d tc=%0b done=%0b",
               tag, act_v[W+1:2], act_v[1], act_v[0], exp_v[W+1:2], exp_v[1], exp_v[0]);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    n_tests++;
    assert ({count, tc, done} === '0) else begin
      n_fail++;
      $error("FAIL %s observed count=%0d tc=%0b done=%0b expected all zero", tag, count, tc, done);
    end
  endtask

  task automatic cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0; dir = 1'b0;
    load_val = '0; limit = '0; mode = 2'b00; prescale = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Legacy free-running behaviour: full 0..255,0 sweep.
    en = 1'b1; prescale = 4'd0; mode = 2'b00; dir = 1'b0; limit = 8'd255;
    cycles(258, "free_run");

    // Prescaled wrap with an enable gap.
    clr = 1'b1; cycle("clr");
    clr = 1'b0; prescale = 4'd3; limit = 8'd5;
    cycles(30, "psc3_wrap");
    en = 1'b0; cycles(10, "en_off_freeze");
    en = 1'b1; cycles(20, "psc3_resume");

    // Saturating down count from a loaded 3.
    prescale = 4'd0; mode = 2'b01; dir = 1'b1; load_val = 8'd3;
    load = 1'b1; cycle("sat_load");
    load = 1'b0; cycles(6, "sat_down");

    // One-shot up to 4, then frozen while done, then reload.
    mode = 2'b10; dir = 1'b0; limit = 8'd4;
    clr = 1'b1; cycle("os_clr");
    clr = 1'b0; cycles(5, "os_run");
    dir = 1'b1; limit = 8'd9; cycles(20, "os_frozen");
    dir = 1'b0; limit = 8'd4;
    load_val = 8'd1; load = 1'b1; cycle("os_reload");
    load = 1'b0; cycles(5, "os_resume");

    // One-shot already at the boundary: done sets without tc.
    load_val = 8'd4; load = 1'b1; cycle("os_bnd_load");
    load = 1'b0; cycles(2, "os_at_bnd");

    // Priority: clr over load over tick.
    mode = 2'b00; clr = 1'b1; load = 1'b1; load_val = 8'd77; cycle("prio_clr_load");
    clr = 1'b0; load_val = 8'd200; limit = 8'd10; cycle("prio_load");
    load = 1'b0; cycles(3, "load_oor_wrap");

    // Down wrap from above the limit, limit=0 and the reserved wrap encoding.
    load_val = 8'd20; load = 1'b1; dir = 1'b1; cycle("down_load");
    load = 1'b0; cycles(25, "down_oor_wrap");
    limit = 8'd0; dir = 1'b0; cycles(4, "lim0_wrap");
    mode = 2'b01; cycles(3, "lim0_sat");
    mode = 2'b11; limit = 8'd2; cycles(6, "mode3_wrap");

    // Prescale lowered below psc: psc must wrap through 15 before matching.
    mode = 2'b00; limit = 8'd100; prescale = 4'd5; clr = 1'b1; cycle("pscw_clr");
    clr = 1'b0; cycles(4, "pscw_pre");
    prescale = 4'd1; cycles(16, "pscw_wrap");

    // Asynchronous reset mid-cycle at count=7, psc=2.
    prescale = 4'd3; load_val = 8'd7; load = 1'b1; cycle("ar_load");
    load = 1'b0; cycles(2, "ar_psc2");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    cycles(9, "after_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/param_counter.md
Name: param_counter

Overview:
- Parametrised successor to the free-running 8-bit top-level counter.
- Adds configurable width, up/down direction, a programmable terminal value, and three end-of-count modes: wrap, saturate and one-shot.
- Adds a programmable clock-enable prescaler, synchronous clear and parallel load.
- Instantiated inside the tt_um top; count and flags map onto uo_out, controls come from ui_in/uio_in.

Parameters:
- WIDTH, 8, bit width of count, limit and load_val.
- PRESCALE_W, 4, bit width of the prescaler counter and of the prescale input.

Ports:
- clk  input  1  single clock; all state on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- en  input  1  count enable; gates the prescaler.
- clr  input  1  synchronous clear.
- load  input  1  synchronous parallel load of load_val.
- load_val  input  WIDTH  value loaded into count.
- dir  input  1  0 = count up, 1 = count down.
- mode  input  2  00 = wrap, 01 = saturate, 10 = one-shot, 11 = wrap (reserved).
- limit  input  WIDTH  terminal value; count range is 0..limit.
- prescale  input  PRESCALE_W  a tick occurs every prescale+1 enabled cycles.
- count  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, registered, one cycle wide.
- done  output  1  one-shot complete flag, sticky.

Behaviour:
- Clock and reset:
  - Single clock clk.
  - rst_n asynchronous, active-low; while low: count=0, psc=0, tc=0, done=0.
  - Release is synchronous to the next clk edge.
- Priority each cycle: clr > load > tick.
  - clr: count<=0, psc<=0, tc<=0, done<=0.
  - load: count<=load_val (no range check), psc<=0, tc<=0, done<=0.
- Prescaler (internal psc, PRESCALE_W bits):
  - en=0: psc holds; no tick.
  - en=1 and psc==prescale: tick=1, psc<=0.
  - en=1 and psc!=prescale: psc<=psc+1.
  - prescale=0: tick on every enabled cycle.
  - If prescale is changed to a value below psc: psc keeps incrementing, wraps at 2^PRESCALE_W, then matches.
- Boundary B: limit when dir=0, 0 when dir=1.
  - "At boundary", up: count>=limit (covers loaded or limit-lowered out-of-range values).
  - "At boundary", down: count==0.
- Per tick, wrap mode (00/11):
  - At boundary: count<=(dir?limit:0), tc<=1.
  - Otherwise: count<=count±1, tc<=0.
- Per tick, saturate mode (01):
  - At boundary: count holds, tc<=0.
  - Otherwise: count<=count±1; tc<=1 iff the new value equals B.
- Per tick, one-shot mode (10):
  - Stepping is as in saturate; on reaching B, tc<=1 and done<=1.
  - While done=1, ticks are ignored and count freezes, even if dir or limit change.
  - done clears only on clr or load, or on reset.
  - Already at boundary with done=0: done<=1, tc<=0, count holds.
- tc is 0 on every cycle without a qualifying tick.
  - tc is asserted in the cycle after the tick edge, coincident with the new count value.
- dir, mode and limit are sampled on each tick edge; changes take effect at the next tick, with no state reset.
- Down count from above limit: decrement normally until 0, then wrap to limit (wrap mode).
- limit=0: wrap mode gives a tc on every tick and count stays 0; saturate gives no tc after the first arrival.
- Arithmetic: all WIDTH-bit unsigned; no carry out beyond the tc semantics above.
- Reset asserted mid-prescale or mid-count: immediate asynchronous clear of all state; no pulse is emitted.

Test Plan:
- Reset, then WIDTH=8, en=1, prescale=0, mode=00, dir=0, limit=255 -> count 0,1,…,255,0; tc=1 exactly in the cycle count returns to 0; matches the legacy free-running counter.
- prescale=3, limit=5, wrap, up -> count advances every 4th cycle 0..5,0; tc high 1 cycle per 24 cycles; en=0 for 10 cycles freezes count and psc.
- mode=01, dir=1, load_val=3 loaded -> 2,1,0, then holds at 0; tc=1 only on the 1->0 step; further ticks keep tc=0.
- mode=10, up, limit=4 from 0 -> count reaches 4, tc and done pulse/set together; 20 more ticks leave count=4, done=1; load 1 -> done=0 and counting resumes.
- Priority: clr and load together with a tick -> count=0, tc=0; load=1 with load_val=200, limit=10, up wrap -> next tick wraps to 0 with tc=1.
- Assert rst_n low asynchronously, mid-cycle, at count=7, psc=2 -> outputs 0 immediately, before the next clk edge; after release the first tick comes prescale+1 cycles later.
